// File: rtl/qpsk_carrier_mapper.sv
// QPSK carrier mapper: buffers one Gray-coded dibit and emits a phase-shifted sine burst per symbol.
// Optional macro QPSK_DIFF_EN turns the phase map into a differential (DQPSK) accumulator.
module qpsk_carrier_mapper #(
    parameter int SAMPLE_W    = 8,
    parameter int CYC_PER_SYM = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 dibit_in,
    input  logic                       dibit_valid,
    output logic                       dibit_ready,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       sym_start,
    output logic                       underrun
);

    localparam int     SPS   = 16 * CYC_PER_SYM;
    localparam int     CNT_W = $clog2(SPS);
    localparam longint AMP   = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
`ifdef QPSK_DIFF_EN
    localparam logic [3:0] OFFSET_RST = 4'd2;
`else
    localparam logic [3:0] OFFSET_RST = 4'd0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    // Quarter-wave sine in Q16, scaled by the amplitude and rounded to nearest.
    function automatic logic signed [SAMPLE_W-1:0] sine_val(input int k);
        int     m;
        longint q;
        longint mag;
        m = k % 8;
        if (m > 4) m = 8 - m;
        case (m)
            0:       q = 0;
            1:       q = 25080;
            2:       q = 46341;
            3:       q = 60547;
            default: q = 65536;
        endcase
        mag = (AMP * q + 64'sd32768) >>> 16;
        if (k >= 8) mag = -mag;
        return mag[SAMPLE_W-1:0];
    endfunction

    function automatic logic [3:0] phase_step(input logic [1:0] d);
        logic [3:0] s;
        case (d)
            2'b00:   s = 4'd0;
            2'b01:   s = 4'd4;
            2'b11:   s = 4'd8;
            default: s = 4'd12;
        endcase
        return s;
    endfunction

    logic signed [SAMPLE_W-1:0] lut [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lut
            assign lut[gi] = sine_val(gi);
        end
    endgenerate

    state_t                     state_reg, state_next;
    logic [1:0]                 buf_reg, buf_next;
    logic                       buf_full_reg, buf_full_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [3:0]                 offset_reg, offset_next;
    logic signed [SAMPLE_W-1:0] sample_next;
    logic                       sample_valid_next, sym_start_next, underrun_next;
    logic                       load, accept;
    logic [3:0]                 idx;

    always_comb begin
        state_next        = state_reg;
        buf_next          = buf_reg;
        buf_full_next     = buf_full_reg;
        cnt_next          = cnt_reg;
        offset_next       = offset_reg;
        sample_valid_next = 1'b0;
        sym_start_next    = 1'b0;
        underrun_next     = 1'b0;
        load              = 1'b0;
        accept            = dibit_valid && !buf_full_reg;

        case (state_reg)
            IDLE: begin
                if (buf_full_reg) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == CNT_W'(SPS - 1)) begin
                    if (buf_full_reg) begin
                        load = 1'b1;
                    end else begin
                        state_next    = IDLE;
                        underrun_next = 1'b1;
                    end
                end else begin
                    cnt_next          = cnt_reg + CNT_W'(1);
                    sample_valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A load needs a full buffer, so it can never coincide with an accept.
        if (load) begin
            cnt_next          = '0;
            buf_full_next     = 1'b0;
            sample_valid_next = 1'b1;
            sym_start_next    = 1'b1;
`ifdef QPSK_DIFF_EN
            offset_next       = offset_reg + phase_step(buf_reg);
`else
            offset_next       = phase_step(buf_reg) + 4'd2;
`endif
        end else if (accept) begin
            buf_full_next = 1'b1;
            buf_next      = dibit_in;
        end

        idx         = cnt_next[3:0] + offset_next;
        sample_next = sample_valid_next ? lut[idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            buf_reg      <= 2'b00;
            buf_full_reg <= 1'b0;
            cnt_reg      <= '0;
            offset_reg   <= OFFSET_RST;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sym_start    <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            cnt_reg      <= cnt_next;
            offset_reg   <= offset_next;
            sample_out   <= sample_next;
            sample_valid <= sample_valid_next;
            sym_start    <= sym_start_next;
            underrun     <= underrun_next;
        end
    end

    assign dibit_ready = !buf_full_reg;

endmodule

// File: tb/tb_qpsk_carrier_mapper.sv
// Scoreboard bench for qpsk_carrier_mapper: stimulus pushes expected samples, a negedge monitor pops and compares.
// Honours QPSK_DIFF_EN for the expected phase model.
module tb_qpsk_carrier_mapper;

    localparam int SPS = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        dibit_in = 2'b00;
    logic              dibit_valid = 1'b0;
    logic              dibit_ready;
    logic signed [7:0] sample_out;
    logic              sample_valid;
    logic              sym_start;
    logic              underrun;

    qpsk_carrier_mapper #(.SAMPLE_W(8), .CYC_PER_SYM(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .dibit_in     (dibit_in),
        .dibit_valid  (dibit_valid),
        .dibit_ready  (dibit_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        bit st;
    } exp_t;

    exp_t exp_q[$];
    int   lut_tb [16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};
    int   n_checks = 0;
    int   n_fail = 0;
    int   under_cycles = 0;
    int   acc_cnt = 0;
    int   run_len = 0;
    int   last_run = 0;
    bit   prev_valid = 1'b0;
`ifdef QPSK_DIFF_EN
    int   acc = 2;
`endif

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int offset_for(input logic [1:0] d);
`ifdef QPSK_DIFF_EN
        int step;
        case (d)
            2'b00:   step = 0;
            2'b01:   step = 4;
            2'b11:   step = 8;
            default: step = 12;
        endcase
        acc = (acc + step) % 16;
        return acc;
`else
        case (d)
            2'b00:   return 2;
            2'b01:   return 6;
            2'b11:   return 10;
            default: return 14;
        endcase
`endif
    endfunction

    task automatic push_symbol(input logic [1:0] d);
        exp_t e;
        int   o;
        o = offset_for(d);
        for (int k = 0; k < SPS; k++) begin
            e.s  = lut_tb[(k + o) % 16];
            e.st = (k == 0);
            exp_q.push_back(e);
        end
        $display("accept dibit=%b offset=%0d first_sample=%0d", d, o, lut_tb[o]);
    endtask

    // Presents a dibit and waits (bounded) for the edge that accepts it.
    task automatic send(input logic [1:0] d, input bit keep, output int waited);
        waited = 0;
        @(negedge clk);
        dibit_in    = d;
        dibit_valid = 1'b1;
        while (!dibit_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!dibit_ready) begin
            check("accept_timeout", 0, 1);
            dibit_valid = 1'b0;
            return;
        end
        push_symbol(d);
        @(posedge clk);
        #1;
        if (!keep) dibit_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (rst && dibit_valid && dibit_ready) acc_cnt++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_out", int'(sample_out), e.s);
                    check("sym_start", int'(sym_start), int'(e.st));
                end
                run_len++;
            end else if (prev_valid) begin
                last_run = run_len;
                run_len  = 0;
                if (exp_q.size() > 0) check("stream_gap", 1, 0);
            end
            if (underrun) begin
                under_cycles++;
                check("underrun_valid_low", int'(sample_valid), 0);
            end
            prev_valid = sample_valid;
        end else begin
            prev_valid = 1'b0;
            run_len    = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int u0;
        int a0;

        repeat (3) @(negedge clk);
        check("reset_outputs", int'({dibit_ready, sample_valid, sym_start, underrun, sample_out}), 2048);
        rst = 1'b1;

        // Idle after reset release with no input
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", int'({dibit_ready, sample_valid, sym_start, underrun, sample_out}), 2048);
        end

        // Single dibit 00 from IDLE, two-clock latency then underrun
        u0 = under_cycles;
        send(2'b00, 1'b0, w);
        @(negedge clk);
        check("latency_edge_n", int'(sample_valid), 0);
        @(negedge clk);
        check("latency_edge_n1", int'(sample_valid && sym_start), 1);
        drain("single_drain");
        check("single_run_len", last_run, 32);
        check("single_underrun", under_cycles - u0, 1);

        // Back-to-back 00 then 11, second offered while running
        u0 = under_cycles;
        send(2'b00, 1'b0, w);
        w = 0;
        while (!sample_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        send(2'b11, 1'b0, w);
        check("b2b_immediate_accept", w, 0);
        @(negedge clk);
        check("b2b_ready_low", int'(dibit_ready), 0);
        drain("b2b_drain");
        check("b2b_run_len", last_run, 64);
        check("b2b_underrun", under_cycles - u0, 1);

        // Continuous valid with 01,10,11,00
        u0 = under_cycles;
        a0 = acc_cnt;
        send(2'b01, 1'b1, w);
        send(2'b10, 1'b1, w);
        send(2'b11, 1'b1, w);
        send(2'b00, 1'b0, w);
        drain("cont_drain");
        check("cont_run_len", last_run, 128);
        check("cont_accepts", acc_cnt - a0, 4);
        check("cont_underrun", under_cycles - u0, 1);

        // Reset at cnt=13 with a dibit buffered
        send(2'b00, 1'b0, w);
        send(2'b11, 1'b0, w);
        repeat (12) @(posedge clk);
        #2;
        check("pre_reset_buffer_full", int'(dibit_ready), 0);
        check("pre_reset_valid", int'(sample_valid), 1);
        rst = 1'b0;
        exp_q.delete();
`ifdef QPSK_DIFF_EN
        acc = 2;
`endif
        #1;
        check("async_reset_outputs", int'({dibit_ready, sample_valid, sym_start, underrun, sample_out}), 2048);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        u0 = under_cycles;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_reset_idle", int'({dibit_ready, sample_valid, sym_start, underrun, sample_out}), 2048);
        end
        check("post_reset_no_underrun", under_cycles - u0, 0);
        send(2'b10, 1'b0, w);
        drain("post_reset_drain");
        check("post_reset_run_len", last_run, 32);

        // Three 01 symbols (differential accumulation when enabled)
        u0 = under_cycles;
        send(2'b01, 1'b1, w);
        send(2'b01, 1'b1, w);
        send(2'b01, 1'b0, w);
        drain("rep01_drain");
        check("rep01_run_len", last_run, 96);
        check("rep01_underrun", under_cycles - u0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
